// File: rtl/ins_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: the NOP encoding, the
// sequencer state codes and the flush-counter width.
package ins_fetch_pkg;

  localparam logic [31:0] INS_NOP    = 32'h0000_0013;
  localparam int          IF_FLUSH_W = 3;

  localparam logic [1:0] IF_FILL  = 2'd0;
  localparam logic [1:0] IF_RUN   = 2'd1;
  localparam logic [1:0] IF_FLUSH = 2'd2;

endpackage

// File: rtl/ins_fetch_if.sv
// Redirect/stall inputs and the IF/ID bundle of the fetch stage; the master
// side is the fetch stage, the slave side is the rest of the pipeline.
interface ins_fetch_if;

  logic [31:0] mb_if__jump_target;
  logic        mb_if__jump_taken;
  logic        id_if__stall;
  logic [31:0] if_id__pc;
  logic [31:0] if_id__ins;
  logic        if_id__valid;
  logic        if_id__ins_misalign;
  logic        pipe_flush;

  modport master (
    input  mb_if__jump_target, mb_if__jump_taken, id_if__stall,
    output if_id__pc, if_id__ins, if_id__valid, if_id__ins_misalign, pipe_flush
  );

  modport slave (
    output mb_if__jump_target, mb_if__jump_taken, id_if__stall,
    input  if_id__pc, if_id__ins, if_id__valid, if_id__ins_misalign, pipe_flush
  );

endinterface

// File: rtl/ins_fetch_imem.sv
// Synchronous-read instruction ROM; contents come from the INIT parameter,
// one 32-bit word per address.
module ins_fetch_imem
  import ins_fetch_pkg::*;
#(
  parameter int unsigned AW              = 11,
  parameter logic [31:0] INIT [1 << AW]  = '{default: INS_NOP}
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   rdata_o
);

  // NOTE: memory read data carries no reset; the fetch FSM masks it until valid.
  always_ff @(posedge clk) begin
    rdata_o <= INIT[addr_i];
  end

endmodule

// File: rtl/ins_fetch.sv
// Instruction-fetch stage: PC register, imem, redirect/flush sequencer.
// Define IF_PERF_EN to add the fetch and redirect performance counters.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC                   = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES               = 3,
  parameter int unsigned IMEM_AW                    = 11,
  parameter logic [31:0] IMEM_INIT [1 << IMEM_AW]   = '{default: INS_NOP}
) (
  input  logic         clk,
  input  logic         rst_n,
  ins_fetch_if.master  bus
`ifdef IF_PERF_EN
  ,
  output logic [31:0]  if_perf__fetch_cnt,
  output logic [31:0]  if_perf__redirect_cnt
`endif
);

  localparam logic [IF_FLUSH_W-1:0] FLUSH_LAST = IF_FLUSH_W'(FLUSH_CYCLES - 1);

  logic [31:0]           pc_q;
  logic [31:0]           fetch_addr;
  logic [1:0]            state_q, state_d;
  logic [IF_FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                  pipe_flush_q;
  logic                  taken_eff;
  logic                  valid;
  logic                  misalign;
  logic [31:0]           rdata;

  // Redirects are honoured only in RUN: FILL wins on reset release, FLUSH ignores them.
  assign taken_eff = bus.mb_if__jump_taken & ~pipe_flush_q & (state_q == IF_RUN);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fetch_addr = pc_q + 32'd4;
    if (taken_eff) begin
      fetch_addr = bus.mb_if__jump_target;
    end else if (bus.id_if__stall || (state_q == IF_FILL)) begin
      fetch_addr = pc_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IF_FILL: state_d = IF_RUN;
      IF_RUN: begin
        if (taken_eff) begin
          state_d     = IF_FLUSH;
          flush_cnt_d = FLUSH_LAST;
        end
      end
      IF_FLUSH: begin
        if (flush_cnt_q == '0) state_d = IF_RUN;
        else                   flush_cnt_d = flush_cnt_q - IF_FLUSH_W'(1);
      end
      default: state_d = IF_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      state_q      <= IF_FILL;
      flush_cnt_q  <= '0;
      pipe_flush_q <= 1'b0;
    end else begin
      pc_q         <= fetch_addr;
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      pipe_flush_q <= (state_d == IF_FLUSH);
    end
  end

  ins_fetch_imem #(
    .AW   (IMEM_AW),
    .INIT (IMEM_INIT)
  ) u_imem (
    .clk     (clk),
    .addr_i  (fetch_addr[IMEM_AW+1:2]),
    .rdata_o (rdata)
  );

  assign valid    = (state_q != IF_FILL);
  assign misalign = valid & (pc_q[1:0] != 2'b00);

  assign bus.if_id__pc           = pc_q;
  assign bus.if_id__ins          = (valid && !misalign) ? rdata : INS_NOP;
  assign bus.if_id__valid        = valid;
  assign bus.if_id__ins_misalign = misalign;
  assign bus.pipe_flush          = pipe_flush_q;

`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (valid && !bus.id_if__stall) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (taken_eff)                  redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign if_perf__fetch_cnt    = fetch_cnt_q;
  assign if_perf__redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: reset, sequential fetch, redirect/flush,
// stall, misaligned target, PC wrap and reset during a flush.
module tb_ins_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W_A = 32'h1111_1111;
  localparam logic [31:0] W_B = 32'h2222_2222;
  localparam logic [31:0] W_C = 32'h3333_3333;
  localparam logic [31:0] W_D = 32'h4444_4444;

  localparam logic [31:0] ROM [2048] = '{
    0: W_A, 1: W_B, 2: W_C, 3: W_D,
    4: 32'h5555_5555, 5: 32'h6666_6666,
    8: 32'h0808_0808, 9: 32'h0909_0909,
    16: 32'h1616_1616, 17: 32'h1717_1717, 18: 32'h1818_1818, 19: 32'h1919_1919,
    default: NOP
  };

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  ins_fetch_if bus ();

`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;
`endif

  ins_fetch #(
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (3),
    .IMEM_AW      (11),
    .IMEM_INIT    (ROM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_PERF_EN
    ,
    .if_perf__fetch_cnt    (fetch_cnt),
    .if_perf__redirect_cnt (redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_if(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic valid, input logic mis, input logic flush);
    check({tag, ".pc"},    bus.if_id__pc,                  pc);
    check({tag, ".ins"},   bus.if_id__ins,                 ins);
    check({tag, ".valid"}, {31'd0, bus.if_id__valid},       {31'd0, valid});
    check({tag, ".mis"},   {31'd0, bus.if_id__ins_misalign},{31'd0, mis});
    check({tag, ".flush"}, {31'd0, bus.pipe_flush},         {31'd0, flush});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [31:0] target);
    bus.mb_if__jump_taken  = 1'b1;
    bus.mb_if__jump_target = target;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n                  = 1'b0;
    bus.mb_if__jump_taken  = 1'b0;
    bus.mb_if__jump_target = 32'h0;
    bus.id_if__stall       = 1'b0;
    tick();
    tick();
    expect_if("reset", 32'h0, NOP, 1'b0, 1'b0, 1'b0);
`ifdef IF_PERF_EN
    check("reset.fetch_cnt",    fetch_cnt,    32'd0);
    check("reset.redirect_cnt", redirect_cnt, 32'd0);
`endif

    // Release reset with a redirect pending: FILL must win.
    rst_n = 1'b1;
    jump(32'h40);
    #1;
    expect_if("fill", 32'h0, NOP, 1'b0, 1'b0, 1'b0);
    tick(); expect_if("seq0", 32'h0, W_A, 1'b1, 1'b0, 1'b0);
    bus.mb_if__jump_taken = 1'b0;
    tick(); expect_if("seq4", 32'h4, W_B, 1'b1, 1'b0, 1'b0);
    tick(); expect_if("seq8", 32'h8, W_C, 1'b1, 1'b0, 1'b0);
    tick(); expect_if("seqC", 32'hC, W_D, 1'b1, 1'b0, 1'b0);

    // Redirect to 0x40, then a pulse during the flush that must be ignored.
    jump(32'h40);
    tick(); expect_if("jmp40", 32'h40, 32'h1616_1616, 1'b1, 1'b0, 1'b1);
    jump(32'h80);
    tick(); expect_if("jmp44", 32'h44, 32'h1717_1717, 1'b1, 1'b0, 1'b1);
    bus.mb_if__jump_taken = 1'b0;
    tick(); expect_if("jmp48", 32'h48, 32'h1818_1818, 1'b1, 1'b0, 1'b1);
    tick(); expect_if("jmp4C", 32'h4C, 32'h1919_1919, 1'b1, 1'b0, 1'b0);

    // Redirect to 0x8, stall while flushing: counter keeps running.
    jump(32'h8);
    tick(); expect_if("st_j8", 32'h8, W_C, 1'b1, 1'b0, 1'b1);
    bus.mb_if__jump_taken = 1'b0;
    bus.id_if__stall      = 1'b1;
    tick(); expect_if("stall1", 32'h8, W_C, 1'b1, 1'b0, 1'b1);
    tick(); expect_if("stall2", 32'h8, W_C, 1'b1, 1'b0, 1'b1);
    tick(); expect_if("stall3", 32'h8, W_C, 1'b1, 1'b0, 1'b0);

    // Redirect overrides stall.
    jump(32'h20);
    tick(); expect_if("st_j20", 32'h20, 32'h0808_0808, 1'b1, 1'b0, 1'b1);
    bus.mb_if__jump_taken = 1'b0;
    bus.id_if__stall      = 1'b0;
    tick(); expect_if("after24", 32'h24, 32'h0909_0909, 1'b1, 1'b0, 1'b1);
    tick(); expect_if("after28", 32'h28, NOP, 1'b1, 1'b0, 1'b1);
    tick(); expect_if("after2C", 32'h2C, NOP, 1'b1, 1'b0, 1'b0);

    // Misaligned target.
    jump(32'h22);
    tick(); expect_if("mis22", 32'h22, NOP, 1'b1, 1'b1, 1'b1);
    bus.mb_if__jump_taken = 1'b0;
    tick(); expect_if("mis26", 32'h26, NOP, 1'b1, 1'b1, 1'b1);
    tick(); expect_if("mis2A", 32'h2A, NOP, 1'b1, 1'b1, 1'b1);
    tick(); expect_if("mis2E", 32'h2E, NOP, 1'b1, 1'b1, 1'b0);

    // PC wrap past 2^32.
    jump(32'hFFFF_FFFC);
    tick(); expect_if("wrapFC", 32'hFFFF_FFFC, NOP, 1'b1, 1'b0, 1'b1);
    bus.mb_if__jump_taken = 1'b0;
    tick(); expect_if("wrap0", 32'h0, W_A, 1'b1, 1'b0, 1'b1);
    tick(); expect_if("wrap4", 32'h4, W_B, 1'b1, 1'b0, 1'b1);
`ifdef IF_PERF_EN
    check("perf.redirect_cnt", redirect_cnt, 32'd5);
`endif

    // Asynchronous reset in the middle of a flush.
    rst_n = 1'b0;
    #1;
    expect_if("rst_mid", 32'h0, NOP, 1'b0, 1'b0, 1'b0);
`ifdef IF_PERF_EN
    check("rst_mid.fetch_cnt",    fetch_cnt,    32'd0);
    check("rst_mid.redirect_cnt", redirect_cnt, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick(); expect_if("rerun0", 32'h0, W_A, 1'b1, 1'b0, 1'b0);
    tick(); expect_if("rerun4", 32'h4, W_B, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
